// File: rtl/command_dispatcher.sv
// Two-byte command dispatcher: address byte then request byte, one-hot select
// strobe to the addressed sensor interface, then wait for its done strobe.
module command_dispatcher #(
    parameter int NUM_IF         = 32,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Data_Done,
    input  logic [NUM_IF-1:0] i_If_Done,
    output logic [DATA_W-1:0] o_request,
    output logic [NUM_IF-1:0] o_interface,
    output logic              o_busy,
    output logic              o_addr_error,
    output logic              o_timeout,
    output logic              o_overrun
);

    localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REQ,
        WAIT_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   address;
    logic [TO_W-1:0]     timer;
    logic [NUM_IF-1:0]   sel_mask;
    logic [NUM_IF-1:0]   addr_onehot;
    logic                timer_expired;
    logic                sel_done;

    // An address outside 0..NUM_IF-1 decodes to all zeros, which doubles as the validity test.
    always_comb begin
        addr_onehot = '0;
        for (int unsigned i = 0; i < NUM_IF; i++) begin
            addr_onehot[i] = (address == DATA_W'(i));
        end
    end

    assign timer_expired = (TIMEOUT_CYCLES != 0) && (timer == TO_LAST);
    // The select strobe is still high during the first WAIT_DONE cycle, so done is ignored then.
    assign sel_done      = ~(|o_interface) && (|(i_If_Done & sel_mask));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= IDLE;
            address      <= '0;
            timer        <= '0;
            sel_mask     <= '0;
            o_request    <= '0;
            o_interface  <= '0;
            o_busy       <= 1'b0;
            o_addr_error <= 1'b0;
            o_timeout    <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_interface  <= '0;
            o_addr_error <= 1'b0;
            o_timeout    <= 1'b0;
            o_overrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_Data_Done) begin
                        address <= i_Data;
                        timer   <= '0;
                        state   <= WAIT_REQ;
                        o_busy  <= 1'b1;
                    end
                end
                WAIT_REQ: begin
                    if (i_Data_Done) begin
                        timer <= '0;
                        if (|addr_onehot) begin
                            o_interface <= addr_onehot;
                            o_request   <= i_Data;
                            sel_mask    <= addr_onehot;
                            state       <= WAIT_DONE;
                        end else begin
                            o_addr_error <= 1'b1;
                            state        <= IDLE;
                            o_busy       <= 1'b0;
                        end
                    end else if (timer_expired) begin
                        o_timeout <= 1'b1;
                        address   <= '0;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                    end else begin
                        timer <= (TIMEOUT_CYCLES == 0) ? '0 : timer + TO_W'(1);
                    end
                end
                WAIT_DONE: begin
                    o_overrun <= i_Data_Done;
                    if (sel_done) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (timer_expired) begin
                        o_timeout <= 1'b1;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                    end else begin
                        timer <= (TIMEOUT_CYCLES == 0) ? '0 : timer + TO_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_command_dispatcher.sv
// Scoreboard bench for command_dispatcher: expected output pulses are queued with
// their due cycle when stimulus is driven and matched as the DUT raises them.
module tb_command_dispatcher;

    localparam int K_DISP = 0;
    localparam int K_AERR = 1;
    localparam int K_TO   = 2;
    localparam int K_OVR  = 3;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic [7:0]  i_Data = '0;
    logic        i_Data_Done = 1'b0;
    logic [31:0] i_If_Done = '0;
    logic [7:0]  o_request;
    logic [31:0] o_interface;
    logic        o_busy;
    logic        o_addr_error;
    logic        o_timeout;
    logic        o_overrun;

    typedef struct {
        int          kind;
        logic [31:0] iface;
        logic [7:0]  req;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   e;
    int   n;

    command_dispatcher #(
        .NUM_IF(32),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_Data(i_Data),
        .i_Data_Done(i_Data_Done),
        .i_If_Done(i_If_Done),
        .o_request(o_request),
        .o_interface(o_interface),
        .o_busy(o_busy),
        .o_addr_error(o_addr_error),
        .o_timeout(o_timeout),
        .o_overrun(o_overrun)
    );

    always #5 i_Clock = ~i_Clock;
    always @(posedge i_Clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input int kind, input logic [31:0] iface, input logic [7:0] req, input int due);
        exp_t x;
        x.kind = kind; x.iface = iface; x.req = req; x.due = due;
        sb.push_back(x);
    endtask

    task automatic sb_pop(input int kind);
        exp_t x;
        if (sb.size() == 0) begin
            check_eq("unexpected_pulse_kind", 64'(kind), 64'hFF);
        end else begin
            x = sb.pop_front();
            check_eq("pulse_kind", 64'(kind), 64'(x.kind));
            check_eq("pulse_cycle", 64'(cyc), 64'(x.due));
            check_eq("pulse_iface", 64'(o_interface), 64'(x.iface));
            check_eq("pulse_req", 64'(o_request), 64'(x.req));
        end
    endtask

    always @(negedge i_Clock) begin
        if (o_interface != '0) sb_pop(K_DISP);
        if (o_addr_error)      sb_pop(K_AERR);
        if (o_timeout)         sb_pop(K_TO);
        if (o_overrun)         sb_pop(K_OVR);
    end

    // Called at posedge+1; the byte is sampled on the next edge, whose number is returned.
    task automatic send_byte(input logic [7:0] b, output int edge_no);
        i_Data = b;
        i_Data_Done = 1'b1;
        @(posedge i_Clock) #1;
        edge_no = cyc;
        i_Data_Done = 1'b0;
    endtask

    task automatic pulse_done(input int idx);
        i_If_Done = 32'(1) << idx;
        @(posedge i_Clock) #1;
        i_If_Done = '0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(posedge i_Clock) #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held three cycles
        i_Reset = 1'b1;
        repeat (3) @(posedge i_Clock);
        #1;
        check_eq("rst_request", 64'(o_request), 0);
        check_eq("rst_interface", 64'(o_interface), 0);
        check_eq("rst_busy", 64'(o_busy), 0);
        check_eq("rst_addr_error", 64'(o_addr_error), 0);
        check_eq("rst_timeout", 64'(o_timeout), 0);
        check_eq("rst_overrun", 64'(o_overrun), 0);
        i_Reset = 1'b0;
        idle_cycles(1);

        // Normal dispatch; a done in the strobe cycle is not accepted
        send_byte(8'h05, e);
        check_eq("busy_after_addr", 64'(o_busy), 1);
        send_byte(8'hA3, e);
        sb_push(K_DISP, 32'h0000_0020, 8'hA3, e);
        check_eq("disp_busy", 64'(o_busy), 1);
        check_eq("disp_request", 64'(o_request), 64'hA3);
        pulse_done(5);
        check_eq("strobe_clear", 64'(o_interface), 0);
        check_eq("done_in_strobe_ignored", 64'(o_busy), 1);
        pulse_done(5);
        check_eq("done5_idle", 64'(o_busy), 0);

        // Invalid addresses, including the first out-of-range one
        send_byte(8'h40, e);
        send_byte(8'h11, e);
        sb_push(K_AERR, 32'h0, 8'hA3, e);
        check_eq("aerr_busy", 64'(o_busy), 0);
        check_eq("aerr_request_held", 64'(o_request), 64'hA3);
        send_byte(8'h20, e);
        send_byte(8'h01, e);
        sb_push(K_AERR, 32'h0, 8'hA3, e);

        // Inter-byte timeout, then normal dispatch to interface 3
        send_byte(8'h02, e);
        sb_push(K_TO, 32'h0, 8'hA3, e + 16);
        idle_cycles(20);
        check_eq("to_busy", 64'(o_busy), 0);
        send_byte(8'h03, e);
        send_byte(8'h55, e);
        sb_push(K_DISP, 32'h0000_0008, 8'h55, e);
        idle_cycles(1);
        pulse_done(3);
        check_eq("done3_idle", 64'(o_busy), 0);

        // Overrun and a foreign done bit while waiting on interface 0
        send_byte(8'h00, e);
        send_byte(8'h66, e);
        sb_push(K_DISP, 32'h0000_0001, 8'h66, e);
        send_byte(8'h77, e);
        sb_push(K_OVR, 32'h0, 8'h66, e);
        check_eq("ovr_busy", 64'(o_busy), 1);
        check_eq("ovr_request_kept", 64'(o_request), 64'h66);
        pulse_done(1);
        check_eq("wrong_done_busy", 64'(o_busy), 1);
        pulse_done(0);
        check_eq("done0_idle", 64'(o_busy), 0);

        // Request byte on the exact expiry cycle wins over the timeout
        send_byte(8'h07, e);
        n = e;
        idle_cycles(15);
        send_byte(8'h42, e);
        check_eq("race_edge", 64'(e), 64'(n + 16));
        sb_push(K_DISP, 32'h0000_0080, 8'h42, e);
        check_eq("race_busy", 64'(o_busy), 1);
        idle_cycles(1);
        pulse_done(7);
        check_eq("done7_idle", 64'(o_busy), 0);

        // Reset in WAIT_REQ discards the partial command
        send_byte(8'h09, e);
        i_Reset = 1'b1;
        @(posedge i_Clock) #1;
        i_Reset = 1'b0;
        check_eq("midrst_busy", 64'(o_busy), 0);
        send_byte(8'h00, e);
        send_byte(8'h01, e);
        sb_push(K_DISP, 32'h0000_0001, 8'h01, e);
        idle_cycles(1);
        pulse_done(0);
        // Back-to-back: address byte in the first IDLE cycle, highest valid address
        send_byte(8'h1F, e);
        send_byte(8'hEE, e);
        sb_push(K_DISP, 32'h8000_0000, 8'hEE, e);
        idle_cycles(1);
        pulse_done(31);
        check_eq("done31_idle", 64'(o_busy), 0);

        idle_cycles(4);
        check_eq("sb_drained", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/command_dispatcher.md
Name: command_dispatcher

Overview:
- Parametrised successor to the UART command selector. Collects a two-byte command (address byte, then request byte) from the RX byte stream.
- Validates the address against NUM_IF, issues a one-cycle one-hot select strobe plus the request byte to the addressed sensor interface, then holds off until that interface reports done.
- Adds inter-byte and completion timeouts, invalid-address and overrun error pulses, and a busy flag. Sits between the UART RX and the sensor interface bank.

Parameters:
NUM_IF, 32, number of sensor interfaces; width of o_interface and i_If_Done; legal range 1..256
DATA_W, 8, RX byte width; width of i_Data, o_request and the address register
TIMEOUT_CYCLES, 1000000, cycles allowed in WAIT_REQ or WAIT_DONE before abort; 0 disables timeout
TO_W, $clog2(TIMEOUT_CYCLES+1), timer width (derived, not overridden)

Ports:
i_Clock  input  1  system clock; all logic on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Data  input  DATA_W  RX byte, valid when i_Data_Done=1
i_Data_Done  input  1  one-cycle strobe from RX: byte available
i_If_Done  input  NUM_IF  per-interface completion strobe
o_request  output  DATA_W  last dispatched request byte; held between dispatches
o_interface  output  NUM_IF  one-hot select strobe, high exactly one cycle per dispatch
o_busy  output  1  high whenever state != IDLE
o_addr_error  output  1  one-cycle pulse: address >= NUM_IF
o_timeout  output  1  one-cycle pulse: timeout abort
o_overrun  output  1  one-cycle pulse: byte dropped while in WAIT_DONE

Behaviour:
- Reset, sampled on the clock edge while i_Reset=1: state IDLE; address, timer, o_request, o_interface, o_addr_error, o_timeout and o_overrun all 0; o_busy 0. Reset mid-command discards the partial command. Reset in WAIT_DONE abandons the wait with no pulses.
- All outputs are registered. Error and strobe pulses last exactly one cycle.
- IDLE: on i_Data_Done, latch i_Data as address, clear timer, go to WAIT_REQ.
- WAIT_REQ:
  - Timer increments each cycle.
  - On i_Data_Done, latch the request and clear the timer.
  - If address < NUM_IF: the next cycle o_interface[address]=1 and o_request=byte (1-cycle latency from the request strobe); state goes to WAIT_DONE.
  - Otherwise: the next cycle o_addr_error=1, o_request unchanged, o_interface stays 0; state goes to IDLE.
  - If timer reaches TIMEOUT_CYCLES-1 with no byte: o_timeout pulses, address is discarded, state goes to IDLE.
  - A byte and timer expiry in the same cycle: the byte wins and no timeout is raised.
- WAIT_DONE:
  - Timer increments each cycle.
  - i_If_Done[selected]=1 returns the state to IDLE. Done bits of other interfaces are ignored.
  - Timer expiry raises o_timeout and returns the state to IDLE.
  - i_Data_Done here drops the byte and pulses o_overrun. This also applies when it coincides with the done strobe or the timeout.
  - A done strobe arriving in the same cycle as the select strobe is not accepted; done is sampled only from the cycle after the strobe.
- Selected index is stored at dispatch; o_interface returns to all zeros after the strobe cycle.
- Back-to-back commands: an address byte arriving in the cycle after the return to IDLE is accepted normally.
- Address compare is unsigned, DATA_W bits wide. When NUM_IF=2^DATA_W, no address is invalid.
- TIMEOUT_CYCLES=0: timer is held at 0 and o_timeout never asserts.

Test Plan:
- Reset: hold i_Reset 3 cycles -> every output 0, o_busy 0; a request byte sent first is treated as the address.
- Normal dispatch, NUM_IF=32: send bytes 0x05 then 0xA3 -> the cycle after the second strobe o_interface=32'h0000_0020 for 1 cycle, o_request=0xA3, o_busy=1. Pulse i_If_Done[5] -> o_busy=0 the next cycle.
- Invalid address: send 0x40 then 0x11 -> o_addr_error pulses 1 cycle, o_interface stays 0, o_request keeps its old value, o_busy=0.
- Inter-byte timeout, TIMEOUT_CYCLES=16: send 0x02 only -> o_timeout pulses 16 cycles later, o_busy=0. A following 0x03,0x55 dispatches to interface 3.
- Overrun and wrong done: while in WAIT_DONE on interface 0, send byte 0x77 -> o_overrun pulses and the byte is ignored. Pulse i_If_Done[1] -> still busy. Pulse i_If_Done[0] -> idle.
- Simultaneous events: request byte on the exact cycle of timer expiry -> dispatch occurs and no o_timeout. Reset asserted in WAIT_REQ -> next command 0x00,0x01 strobes o_interface[0].
